// File: rtl/apb_sec_master.sv
// apb_sec_master: single-outstanding APB initiator with a wait-state timeout.
// A valid/ready command is turned into one APB SETUP/ACCESS transfer. The
// result is returned on a valid/ready response channel. A slave that holds
// pready low for TIMEOUT ACCESS cycles is abandoned and the response is
// flagged with rsp_err and rsp_timeout.
//
// Ports
//   pclk, prst           clock, asynchronous active-high reset
//   req_vld/req_rdy      command handshake
//   req_addr/write/wdata/prot   command payload
//   rsp_vld/rsp_rdy      response handshake
//   rsp_rdata/err/timeout       response payload
//   psel/penable/paddr/pwrite/pwdata/pprot  APB request side
//   prdata/pready/pslverr       APB completion side
module apb_sec_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_prot,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [2:0]        pprot,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TO_W-1:0]     r_cnt;
    logic [TO_W-1:0]     w_cnt_nxt;

    logic                r_req_rdy;
    logic                r_psel;
    logic                r_penable;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [PROT_W-1:0]   r_pprot;
    logic                r_rsp_vld;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    logic                w_req_rdy_nxt;
    logic                w_psel_nxt;
    logic                w_penable_nxt;
    logic [ADDR_W-1:0]   w_paddr_nxt;
    logic                w_pwrite_nxt;
    logic [DATA_W-1:0]   w_pwdata_nxt;
    logic [PROT_W-1:0]   w_pprot_nxt;
    logic                w_rsp_vld_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                w_rsp_err_nxt;
    logic                w_rsp_timeout_nxt;

    logic                w_accept;
    logic                w_done;
    logic                w_abort;
    logic                w_to_hit;

    // r_req_rdy is only ever high in IDLE, so it doubles as the accept qualifier.
    assign w_accept = req_vld & r_req_rdy;

    // Final allowed ACCESS cycle; TIMEOUT==0 never fires.
    assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_W'(TIMEOUT - 1));

    // State and registered outputs.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req_rdy     <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pprot       <= '0;
            r_rsp_vld     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_req_rdy     <= w_req_rdy_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pprot       <= w_pprot_nxt;
            r_rsp_vld     <= w_rsp_vld_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // pready in the last allowed cycle takes priority over the abort.
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_to_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; APB strobes follow the next state.
    always_comb begin
        w_req_rdy_nxt     = (w_state_nxt == S_IDLE);
        w_psel_nxt        = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
        w_penable_nxt     = (w_state_nxt == S_ACCESS);
        w_paddr_nxt       = r_paddr;
        w_pwrite_nxt      = r_pwrite;
        w_pwdata_nxt      = r_pwdata;
        w_pprot_nxt       = r_pprot;
        w_rsp_vld_nxt     = r_rsp_vld;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_cnt_nxt         = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_paddr_nxt  = req_addr;
                    w_pwrite_nxt = req_write;
                    w_pwdata_nxt = req_wdata;
                    w_pprot_nxt  = req_prot;
                end
            end
            S_SETUP: begin
                w_cnt_nxt = '0;
            end
            S_ACCESS: begin
                if (w_done) begin
                    w_rsp_vld_nxt     = 1'b1;
                    w_rsp_rdata_nxt   = r_pwrite ? '0 : prdata;
                    w_rsp_err_nxt     = pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                end else begin
                    // Saturating so a large TIMEOUT or a disabled timeout never wraps.
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + TO_W'(1);
                    end
                    if (w_abort) begin
                        w_rsp_vld_nxt     = 1'b1;
                        w_rsp_rdata_nxt   = '0;
                        w_rsp_err_nxt     = 1'b1;
                        w_rsp_timeout_nxt = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    w_rsp_vld_nxt = 1'b0;
                end
            end
            default: begin
                w_rsp_vld_nxt = 1'b0;
            end
        endcase
    end

    assign req_rdy     = r_req_rdy;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign paddr       = r_paddr;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign pprot       = r_pprot;
    assign rsp_vld     = r_rsp_vld;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_sec_master.sv
// Bench for apb_sec_master: a reactive APB slave, a timeline model that
// predicts every output from the accept cycle and the slave's wait count,
// and directed transfers with literal expectations.
module tb_apb_sec_master;

    localparam int unsigned ADDR_W = 32;
    localparam int          TMO    = 16;
    localparam int unsigned TO_W   = 16;

    logic        pclk;
    logic        prst;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [2:0]  req_prot;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_sec_master #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TMO),
        .TO_W   (TO_W)
    ) dut (
        .pclk       (pclk),
        .prst       (prst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_prot   (req_prot),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pprot      (pprot),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    int n_pass;
    int n_total;
    int cyc;

    // Slave configuration for the current transfer.
    int          slv_wait;
    logic        slv_err;
    logic [31:0] slv_rdata;
    int          slv_acc;

    // Model state.
    bit          m_busy;
    int          m_a;
    int          m_n;
    int          m_idle_from;
    int          rel;
    bit          m_to;
    logic [31:0] m_paddr;
    logic [31:0] m_pwdata;
    logic        m_pwrite;
    logic [2:0]  m_pprot;
    logic [31:0] m_erdata;
    logic        m_eerr;
    logic        m_eto;

    // Observations for the literal checks.
    int          obs_pen;
    int          obs_lat;
    bit          obs_lat_seen;
    int          last_acc;
    int          last_hs;
    int          last_pen;
    int          last_lat;
    logic [31:0] last_rdata;
    logic        last_err;
    logic        last_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge pclk);
            cyc++;
        end
    end

    // Slave: pready low for slv_wait ACCESS cycles, then high.
    initial begin
        slv_acc = 0;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (penable && !prst) begin
                pready = (slv_acc >= slv_wait);
                slv_acc++;
            end else begin
                slv_acc = 0;
                pready  = 1'b0;
            end
            prdata  = slv_rdata;
            pslverr = slv_err;
        end
    end

    // Timeline model and per-cycle compare.
    initial begin
        m_busy = 0; m_idle_from = 0; m_a = 0; m_n = 0; m_to = 0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_pprot = '0;
        m_erdata = '0; m_eerr = 1'b0; m_eto = 1'b0;
        obs_pen = 0; obs_lat = 0; obs_lat_seen = 0;
        last_acc = 0; last_hs = 0; last_pen = 0; last_lat = 0;
        last_rdata = '0; last_err = 1'b0; last_to = 1'b0;
        forever begin
            @(negedge pclk);
            if (prst) begin
                chkb("rst_req_rdy", req_rdy, 1'b0);
                chkb("rst_psel", psel, 1'b0);
                chkb("rst_penable", penable, 1'b0);
                chkb("rst_rsp_vld", rsp_vld, 1'b0);
                chkb("rst_rsp_err", rsp_err, 1'b0);
                chkb("rst_rsp_timeout", rsp_timeout, 1'b0);
                chkb("rst_pwrite", pwrite, 1'b0);
                chk("rst_rsp_rdata", rsp_rdata, 32'h0);
                chk("rst_paddr", paddr, 32'h0);
                chk("rst_pwdata", pwdata, 32'h0);
                chk("rst_pprot", 32'(pprot), 32'h0);
                m_busy = 0;
                m_idle_from = cyc + 2;
                m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_pprot = '0;
            end else begin
                chk("paddr", paddr, m_paddr);
                chk("pwdata", pwdata, m_pwdata);
                chkb("pwrite", pwrite, m_pwrite);
                chk("pprot", 32'(pprot), 32'(m_pprot));
                if (!m_busy) begin
                    chkb("idle_req_rdy", req_rdy, cyc >= m_idle_from);
                    chkb("idle_psel", psel, 1'b0);
                    chkb("idle_penable", penable, 1'b0);
                    chkb("idle_rsp_vld", rsp_vld, 1'b0);
                    if (req_vld && cyc >= m_idle_from) begin
                        m_busy   = 1;
                        m_a      = cyc;
                        m_to     = (TMO != 0) && (slv_wait >= TMO);
                        m_n      = m_to ? TMO : slv_wait + 1;
                        m_paddr  = req_addr;
                        m_pwdata = req_wdata;
                        m_pwrite = req_write;
                        m_pprot  = req_prot;
                        m_erdata = (m_to || req_write) ? 32'h0 : slv_rdata;
                        m_eerr   = m_to || slv_err;
                        m_eto    = m_to;
                        obs_pen  = 0;
                        obs_lat_seen = 0;
                        last_acc = cyc;
                    end
                end else begin
                    rel = cyc - m_a;
                    chkb("busy_req_rdy", req_rdy, 1'b0);
                    chkb("psel", psel, rel >= 1 && rel <= m_n + 1);
                    chkb("penable", penable, rel >= 2 && rel <= m_n + 1);
                    chkb("rsp_vld", rsp_vld, rel >= m_n + 2);
                    if (penable) obs_pen++;
                    if (rsp_vld && !obs_lat_seen) begin
                        obs_lat = rel;
                        obs_lat_seen = 1;
                    end
                    if (rel >= m_n + 2) begin
                        chk("rsp_rdata", rsp_rdata, m_erdata);
                        chkb("rsp_err", rsp_err, m_eerr);
                        chkb("rsp_timeout", rsp_timeout, m_eto);
                        if (rsp_rdy) begin
                            m_busy      = 0;
                            m_idle_from = cyc + 1;
                            last_hs     = cyc;
                            last_pen    = obs_pen;
                            last_lat    = obs_lat;
                            last_rdata  = rsp_rdata;
                            last_err    = rsp_err;
                            last_to     = rsp_timeout;
                        end
                    end
                end
            end
        end
    end

    task automatic start_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [2:0] prot);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_prot  = prot;
        req_vld   = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge pclk);
            if (req_vld && req_rdy) ok = 1;
        end
        @(posedge pclk);
        #1;
        req_vld = 1'b0;
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s_accept: request not accepted within 100 cycles, required acceptance", name);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge pclk);
            if (rsp_vld && rsp_rdy) ok = 1;
        end
        @(posedge pclk);
        #1;
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s_rsp: no response handshake within 100 cycles, required a response", name);
    endtask

    task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [2:0] prot, input int wait_n,
                        input logic err, input logic [31:0] rd);
        slv_wait  = wait_n;
        slv_err   = err;
        slv_rdata = rd;
        start_req(addr, wr, wd, prot);
        wait_accept(name);
        wait_done(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_total = 0;
        prst = 1'b1; req_vld = 1'b0; rsp_rdy = 1'b1;
        req_addr = '0; req_write = 1'b0; req_wdata = '0; req_prot = '0;
        slv_wait = 0; slv_err = 1'b0; slv_rdata = '0;
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        @(posedge pclk);
        #1;

        // Zero-wait write.
        xfer("wr0", 32'h0000_0010, 1'b1, 32'hA5A5_0001, 3'b010, 0, 1'b0, 32'hDEAD_BEEF);
        chk("wr0_lat", 32'(last_lat), 32'd3);
        chk("wr0_pen", 32'(last_pen), 32'd1);
        chk("wr0_rdata", last_rdata, 32'h0);
        chkb("wr0_err", last_err, 1'b0);

        // Read with three wait states.
        xfer("rd3", 32'h0000_0004, 1'b0, 32'h0, 3'b001, 3, 1'b0, 32'h1234_5678);
        chk("rd3_pen", 32'(last_pen), 32'd4);
        chk("rd3_lat", 32'(last_lat), 32'd6);
        chk("rd3_rdata", last_rdata, 32'h1234_5678);
        chkb("rd3_err", last_err, 1'b0);
        chkb("rd3_to", last_to, 1'b0);

        // Read with slave error.
        xfer("rderr", 32'h0000_0008, 1'b0, 32'h0, 3'b000, 0, 1'b1, 32'hCAFE_F00D);
        chkb("rderr_err", last_err, 1'b1);
        chkb("rderr_to", last_to, 1'b0);
        chk("rderr_rdata", last_rdata, 32'hCAFE_F00D);

        // Hung slave: abort after 16 ACCESS cycles.
        xfer("tmo", 32'h0000_000C, 1'b0, 32'h0, 3'b111, 1000, 1'b0, 32'h5555_AAAA);
        chk("tmo_pen", 32'(last_pen), 32'd16);
        chk("tmo_lat", 32'(last_lat), 32'd18);
        chkb("tmo_err", last_err, 1'b1);
        chkb("tmo_to", last_to, 1'b1);
        chk("tmo_rdata", last_rdata, 32'h0);

        // pready in the 16th ACCESS cycle completes normally.
        xfer("edge", 32'h0000_001C, 1'b0, 32'h0, 3'b100, 15, 1'b0, 32'h0BAD_CAFE);
        chk("edge_pen", 32'(last_pen), 32'd16);
        chkb("edge_to", last_to, 1'b0);
        chkb("edge_err", last_err, 1'b0);
        chk("edge_rdata", last_rdata, 32'h0BAD_CAFE);

        // Response back-pressure with a second request waiting.
        rsp_rdy   = 1'b0;
        slv_wait  = 0;
        slv_err   = 1'b0;
        slv_rdata = 32'h0000_0077;
        start_req(32'h0000_0020, 1'b1, 32'h1111_2222, 3'b011);
        wait_accept("bp1");
        start_req(32'h0000_0024, 1'b0, 32'h0, 3'b001);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge pclk);
                if (rsp_vld) seen = 1;
            end
            chkb("bp1_rsp_seen", seen, 1'b1);
        end
        repeat (10) @(posedge pclk);
        #1 rsp_rdy = 1'b1;
        wait_accept("bp2");
        chk("bp_accept_gap", 32'(last_acc - last_hs), 32'd1);
        wait_done("bp2");
        chk("bp2_rdata", last_rdata, 32'h0000_0077);

        // Reset in the middle of a stalled ACCESS.
        slv_wait = 1000;
        start_req(32'h0000_0030, 1'b0, 32'h0, 3'b000);
        wait_accept("rst");
        repeat (2) @(posedge pclk);
        #1;
        chkb("pre_rst_penable", penable, 1'b1);
        prst = 1'b1;
        #1;
        chkb("rst_async_psel", psel, 1'b0);
        chkb("rst_async_penable", penable, 1'b0);
        chkb("rst_async_rsp_vld", rsp_vld, 1'b0);
        chkb("rst_async_req_rdy", req_rdy, 1'b0);
        repeat (2) @(posedge pclk);
        #1 prst = 1'b0;
        repeat (4) @(posedge pclk);
        #1;

        // Normal operation after reset.
        xfer("post", 32'h0000_0040, 1'b0, 32'h0, 3'b010, 0, 1'b0, 32'hFACE_0042);
        chk("post_rdata", last_rdata, 32'hFACE_0042);
        chk("post_lat", 32'(last_lat), 32'd3);

        repeat (3) @(posedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
